// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Contents: byte width, FSM state encoding, stream field order, and a
// state decode helper that tells whether a state takes a stream byte.
package program_loader_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned STATE_W = 3;

   // FSM state encoding
   localparam logic [STATE_W-1:0] S_CNT_HI  = 3'd0;
   localparam logic [STATE_W-1:0] S_CNT_LO  = 3'd1;
   localparam logic [STATE_W-1:0] S_DATA_HI = 3'd2;
   localparam logic [STATE_W-1:0] S_DATA_LO = 3'd3;
   localparam logic [STATE_W-1:0] S_WRITE   = 3'd4;
   localparam logic [STATE_W-1:0] S_CHECK   = 3'd5;
   localparam logic [STATE_W-1:0] S_DONE    = 3'd6;
   localparam logic [STATE_W-1:0] S_ERROR   = 3'd7;

   // Order of fields in the incoming byte stream
   typedef enum logic [2:0] {
      FLD_CNT_HI,
      FLD_CNT_LO,
      FLD_DATA_HI,
      FLD_DATA_LO,
      FLD_CHK
   } stream_field_e;

   // States that consume a byte from the stream
   function automatic logic accepts_byte(input logic [STATE_W-1:0] s);
      return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA_HI) ||
             (s == S_DATA_LO) || (s == S_CHECK);
   endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// loader_checksum: running XOR accumulator over stream bytes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the accumulation (combined with en, loads din)
//   en        : XOR din into the accumulator this cycle
//   din       : incoming byte
//   match_c   : combinational, accumulator equals din
module loader_checksum
   import program_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [BYTE_W-1:0] din,
   output logic              match_c
);

   logic [BYTE_W-1:0] sum_q;
   logic [BYTE_W-1:0] sum_d;

   // next accumulator value
   always_comb begin
      sum_d = sum_q;
      if (clr) sum_d = '0;
      if (en)  sum_d = sum_d ^ din;
   end

   always_ff @(posedge clk) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
   end

   assign match_c = (sum_q == din);

endmodule

// File: rtl/program_loader.sv
// program_loader: assembles a big-endian byte stream into 16-bit words,
// writes them to RAM from BASE_ADDR upward, verifies a trailing XOR
// checksum and releases the CPU reset only on a good image.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_data     : byte stream, accepted when in_valid && in_ready
//   in_ready             : loader can take a byte this cycle
//   mem_we/addr/wdata    : RAM write port, one-cycle pulse per word
//   cpu_rst              : CPU reset, high until a good image is loaded
//   done / error         : sticky load-complete / checksum-mismatch flags
//   words_loaded         : words written since the last reset
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [BYTE_W-1:0]     in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           words_loaded
);

   logic [STATE_W-1:0]    state_q,     state_d;
   logic [BYTE_W-1:0]     hi_q,        hi_d;
   logic [15:0]           remain_q,    remain_d;
   logic [15:0]           words_q,     words_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  cpu_rst_q,   cpu_rst_d;
   logic                  done_q,      done_d;
   logic                  error_q,     error_d;
   logic                  rdy_q,       rdy_d;

   logic accept;
   logic chk_match_c;
   logic [15:0] cnt_word;

   assign accept   = in_valid && rdy_q;
   assign cnt_word = {hi_q, in_data};

   // count bytes and data bytes feed the checksum; the CHK byte is compared
   loader_checksum u_checksum (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept && (state_q == S_CNT_HI)),
      .en      (accept && (state_q != S_CHECK)),
      .din     (in_data),
      .match_c (chk_match_c)
   );

   // next-state and output computation
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      remain_d    = remain_q;
      words_d     = words_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_CNT_HI: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (accept) begin
               remain_d = cnt_word;
               state_d  = (cnt_word != 16'd0) ? S_DATA_HI : S_CHECK;
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               mem_wdata_d = DATA_WIDTH'(cnt_word);
               mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(words_q);
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            // remain_q still counts the word being written now
            words_d  = words_q + 16'd1;
            remain_d = remain_q - 16'd1;
            state_d  = (remain_q == 16'd1) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (accept) state_d = chk_match_c ? S_DONE : S_ERROR;
         end
         default: begin
            state_d = state_q;
         end
      endcase

      // outputs registered from the next state so they line up with it
      mem_we_d  = (state_d == S_WRITE);
      rdy_d     = accepts_byte(state_d);
      done_d    = (state_d == S_DONE);
      error_d   = (state_d == S_ERROR);
      cpu_rst_d = !done_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_CNT_HI;
         hi_q        <= '0;
         remain_q    <= '0;
         words_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= '0;
         cpu_rst_q   <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rdy_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         remain_q    <= remain_d;
         words_q     <= words_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         done_q      <= done_d;
         error_q     <= error_d;
         rdy_q       <= rdy_d;
      end
   end

   // ready is withheld while reset is asserted
   assign in_ready     = rdy_q && !rst;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign cpu_rst      = cpu_rst_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: two instances (base 0 and base 0xFFFF)
// share one byte stream; a stream-level model predicts writes and flags.
`timescale 1ns/1ps
module tb_program_loader;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam logic [AW-1:0] BASE_A = 16'h0000;
   localparam logic [AW-1:0] BASE_B = 16'hFFFF;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data  = 8'h00;

   logic          rdy_a, we_a, crst_a, done_a, err_a;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] wdata_a;
   logic [15:0]   wl_a;
   logic          rdy_b, we_b, crst_b, done_b, err_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] wdata_b;
   logic [15:0]   wl_b;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  img[$];
   logic [31:0] wr_a[$];
   logic [31:0] wr_b[$];
   bit          loading = 1'b0;

   always #5 clk = ~clk;

   program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE_A)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .cpu_rst(crst_a), .done(done_a), .error(err_a), .words_loaded(wl_a));

   program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE_B)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .cpu_rst(crst_b), .done(done_b), .error(err_b), .words_loaded(wl_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // capture writes; while loading, ready must drop exactly on write cycles
   always @(negedge clk) begin
      if (we_a) wr_a.push_back({addr_a, wdata_a});
      if (we_b) wr_b.push_back({addr_b, wdata_b});
      if (loading) begin
         check("load_a", 32'({rdy_a, crst_a, done_a, err_a}), 32'({!we_a, 3'b100}));
         check("load_b", 32'({rdy_b, crst_b, done_b, err_b}), 32'({!we_b, 3'b100}));
      end
   end

   function automatic logic [31:0] exp_wr(input logic [AW-1:0] base, input int i);
      logic [AW-1:0] a;
      a = base + AW'(i);
      return {a, img[2+2*i], img[3+2*i]};
   endfunction

   task automatic check_writes(input int nw);
      check("wr_cnt_a", 32'(wr_a.size()), 32'(nw));
      check("wr_cnt_b", 32'(wr_b.size()), 32'(nw));
      for (int i = 0; i < nw; i++) begin
         if (i < wr_a.size()) check("wr_a", wr_a[i], exp_wr(BASE_A, i));
         if (i < wr_b.size()) check("wr_b", wr_b[i], exp_wr(BASE_B, i));
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      loading  = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      check("rst_a", 32'({rdy_a, we_a, crst_a, done_a, err_a}), 32'(5'b00100));
      check("rst_b", 32'({rdy_b, we_b, crst_b, done_b, err_b}), 32'(5'b00100));
      check("rst_wl", 32'({wl_a, wl_b}), 32'd0);
      check("rst_addr", 32'({addr_a, addr_b}), 32'({BASE_A, BASE_B}));
      check("rst_wdata", 32'({wdata_a, wdata_b}), 32'd0);
      rst = 1'b0;
   endtask

   // drive the first n_send bytes of img, with gaps of gmin..gmax cycles
   task automatic send(input int n_send, input int gmin, input int gmax);
      int w;
      loading = 1'b1;
      for (int i = 0; i < n_send; i++) begin
         in_valid = 1'b1;
         in_data  = img[i];
         w = 0;
         @(negedge clk);
         while (!rdy_a && w < 20) begin
            @(negedge clk);
            w++;
         end
         check("hs_bound", 32'(w < 20), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         if (i == n_send - 1) loading = 1'b0;
         else repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
      end
   endtask

   // predict result from the stream rules, then hold in_valid in the terminal state
   task automatic verify_full(input int idle);
      int n;
      logic [7:0] x;
      bit good;
      n = int'({img[0], img[1]});
      x = 8'h00;
      for (int i = 0; i < img.size() - 1; i++) x = x ^ img[i];
      good = (x == img[img.size()-1]);
      check_writes(n);
      check("final_a", 32'({done_a, err_a, crst_a}), 32'({good, !good, !good}));
      check("final_b", 32'({done_b, err_b, crst_b}), 32'({good, !good, !good}));
      check("wl_a", 32'(wl_a), 32'(n));
      check("wl_b", 32'(wl_b), 32'(n));
      in_valid = 1'b1;
      repeat (idle) begin
         in_data = 8'($urandom);
         @(posedge clk); #1;
         check("term_a", 32'({rdy_a, we_a, done_a, err_a, crst_a}), 32'({2'b00, good, !good, !good}));
         check("term_b", 32'({rdy_b, we_b, done_b, err_b, crst_b}), 32'({2'b00, good, !good, !good}));
      end
      in_valid = 1'b0;
      check_writes(n);
   endtask

   task automatic run_case(input int gmin, input int gmax, input int idle);
      do_reset();
      wr_a.delete();
      wr_b.delete();
      send(img.size(), gmin, gmax);
      verify_full(idle);
   endtask

   task automatic build_random(input int n, input bit bad);
      logic [7:0] x;
      img.delete();
      img.push_back(8'(n >> 8));
      img.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
      x = 8'h00;
      foreach (img[i]) x = x ^ img[i];
      if (bad) x = x ^ 8'($urandom_range(255, 1));
      img.push_back(x);
   endtask

   initial begin
      do_reset();

      img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      run_case(0, 0, 5);
      img = '{8'h00, 8'h00, 8'h00};
      run_case(0, 0, 5);
      img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      run_case(0, 0, 100);
      img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      run_case(3, 3, 5);

      // abandon a load after the second HI byte, then load a fresh image
      img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
      do_reset();
      wr_a.delete();
      wr_b.delete();
      send(5, 0, 0);
      do_reset();
      check_writes(1);
      wr_a.delete();
      wr_b.delete();
      img = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE};
      send(img.size(), 0, 0);
      verify_full(5);

      // address wrap on the high-base instance
      img = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
      run_case(0, 0, 5);

      for (int it = 0; it < 30; it++) begin
         int n;
         n = $urandom_range(6, 0);
         build_random(n, $urandom_range(3, 0) == 0);
         if ($urandom_range(4, 0) == 0) begin
            int ns;
            int pw;
            ns = $urandom_range(img.size() - 1, 1);
            pw = (ns >= 3) ? (ns - 2) / 2 : 0;
            if (pw > n) pw = n;
            do_reset();
            wr_a.delete();
            wr_b.delete();
            send(ns, 0, 2);
            do_reset();
            check_writes(pw);
         end else begin
            run_case(0, 2, 3);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule
